decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameters: none; opcode/funct/ALUOp encodings come from the shared package.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 Instr  input  32  fetched MIPS instruction word.
REQ-005 InstrValid  input  1  Instr is valid this cycle.
REQ-006 ExStall  input  1  downstream cannot accept; hold both stage registers.
REQ-007 Flush  input  1  taken branch/jump resolved; kill younger instructions.
REQ-008 ReadRegister1  output  5  rs of IF/ID instruction, driven to regFile.
REQ-009 ReadRegister2  output  5  rt of IF/ID instruction, driven to regFile.
REQ-010 FetchStall  output  1  fetch must re-present the same Instr next cycle.
REQ-011 DecValid  output  1  ID/EX holds a real instruction.
REQ-012 WriteRegister  output  5  destination register, registered.
REQ-013 RegWrite  output  1  destination write enable, registered.
REQ-014 Ctrl  output  10  {ALUOp[2:0], ALUSrc, MemRead, MemWrite, MemToReg, Branch, Jump, Link}, registered.
REQ-015 ImmExt  output  32  sign-extended imm16, registered.
REQ-016 JumpIndex  output  26  instr[25:0], registered.
REQ-017 IllegalInstr  output  1  one-cycle pulse: unsupported opcode/funct reached ID/EX.

Function
REQ-018 Two register stages SHALL exist:
- IF/ID: instruction word plus valid bit.
- ID/EX: every registered output.
REQ-019 ReadRegister1/2 SHALL be combinational from IF/ID, so the regFile's clocked read of these registers lines up with the ID/EX capture.
REQ-020 Supported instructions SHALL be:
- R-type (opcode 0): funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
- addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02, jal 0x03.
REQ-021 ALUOp encoding SHALL be add=0, sub=1, and=2, or=3, slt=4.
- addi, lw and sw use add with ALUSrc=1.
- beq uses sub with Branch=1.
REQ-022 WriteRegister SHALL be:
- rd for R-type;
- rt for addi and lw;
- 31 for jal (Link=1);
- 0 otherwise.
REQ-023 RegWrite SHALL be forced to 0 whenever WriteRegister==0.
REQ-024 An unsupported opcode or funct in a valid IF/ID entry SHALL load a bubble into ID/EX and pulse IllegalInstr for one cycle.
REQ-025 A bubble SHALL be DecValid=0, RegWrite=0, Ctrl=0, WriteRegister=0; ImmExt and JumpIndex are don't-care.
REQ-026 Load-use hazard SHALL be asserted when all of the following hold:
- ID/EX holds a valid lw with WriteRegister!=0;
- the IF/ID instruction is valid;
- the IF/ID instruction reads that register: rs for all except j/jal; rt additionally for R-type, sw and beq.
REQ-027 On a load-use hazard: FetchStall=1, IF/ID holds, ID/EX loads a bubble; exactly one bubble per hazard.
REQ-028 Per-edge priority SHALL be: rst > Flush > ExStall > load-use > normal advance.
REQ-029 Flush SHALL load bubbles into both IF/ID and ID/EX and suppress that cycle's load-use stall.
REQ-030 ExStall SHALL hold both registers unchanged and assert FetchStall.
REQ-031 Latency SHALL be two edges from Instr/InstrValid capture to registered outputs when no stall occurs.
REQ-032 Throughput SHALL be one instruction per cycle.

Reset
REQ-033 rst SHALL asynchronously clear IF/ID (valid=0) and all ID/EX outputs to 0.
REQ-034 While rst is asserted: FetchStall=0, IllegalInstr=0, ReadRegister1/2=0.
REQ-035 Reset mid-stall SHALL discard the held instruction; no state survives reset.

Structure
REQ-036 Package isa_pkg SHALL hold:
- opcode and funct constants;
- ALUOp encodings;
- Ctrl bit positions.
REQ-037 Sub-module decode_ctrl SHALL be purely combinational (instruction -> Ctrl, WriteRegister, RegWrite, illegal); decode_stage owns all registers and hazard logic.

Verification
REQ-038 add $3,$1,$2 (0x00221820), no stalls -> after 2 edges: DecValid=1, WriteRegister=3, RegWrite=1, ALUOp=0, ALUSrc=0.
REQ-039 lw $5,4($0) then add $6,$5,$1 -> one-cycle FetchStall=1, one bubble (DecValid=0), then add with WriteRegister=6.
REQ-040 lw $0,0($1) then add $2,$0,$0 -> no stall (register 0); lw shows RegWrite=0.
REQ-041 jal 0x0000100 -> WriteRegister=31, RegWrite=1, Link=1, Jump=1, JumpIndex=0x0000100.
REQ-042 Flush and ExStall asserted together while a hazard is pending -> both stages bubble, FetchStall=0.
REQ-043 Opcode 0x3F, then rst asserted mid-stall -> IllegalInstr pulses once; all outputs are 0 immediately on rst, asynchronously.

Source files
------------

// File: rtl/isa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : isa_pkg
// Description : MIPS subset encodings shared by the decode stage and its
//               control decoder: opcodes, functs, ALUOp values, Ctrl layout.
// Revision    : 1.0 - initial release
// ============================================================================
package isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    // Ctrl = {ALUOp[2:0], ALUSrc, MemRead, MemWrite, MemToReg, Branch, Jump, Link}
    localparam int CTRL_W         = 10;
    localparam int CTRL_ALUOP_MSB = 9;
    localparam int CTRL_ALUOP_LSB = 7;
    localparam int CTRL_ALUSRC    = 6;
    localparam int CTRL_MEMREAD   = 5;
    localparam int CTRL_MEMWRITE  = 4;
    localparam int CTRL_MEMTOREG  = 3;
    localparam int CTRL_BRANCH    = 2;
    localparam int CTRL_JUMP      = 1;
    localparam int CTRL_LINK      = 0;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : decode_ctrl
// Description : Purely combinational instruction decoder producing Ctrl,
//               destination register, write enable and an illegal flag.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_ctrl
    import isa_pkg::*;
(
    input  logic [5:0]        i_opcode,
    input  logic [5:0]        i_funct,
    input  logic [4:0]        i_rt,
    input  logic [4:0]        i_rd,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [4:0]        o_write_reg,
    output logic              o_reg_write,
    output logic              o_illegal,
    output logic              o_reads_rs,
    output logic              o_reads_rt
);

    logic [CTRL_W-1:0] w_ctrl;
    logic [4:0]        w_write_reg;
    logic              w_writes;
    logic              w_illegal;

    always_comb begin
        w_ctrl      = '0;
        w_write_reg = REG_ZERO;
        w_writes    = 1'b0;
        w_illegal   = 1'b0;
        o_reads_rs  = 1'b1;
        o_reads_rt  = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                w_write_reg = i_rd;
                w_writes    = 1'b1;
                o_reads_rt  = 1'b1;
                case (i_funct)
                    FN_ADD:  w_ctrl[CTRL_ALUOP_MSB:CTRL_ALUOP_LSB] = ALU_ADD;
                    FN_SUB:  w_ctrl[CTRL_ALUOP_MSB:CTRL_ALUOP_LSB] = ALU_SUB;
                    FN_AND:  w_ctrl[CTRL_ALUOP_MSB:CTRL_ALUOP_LSB] = ALU_AND;
                    FN_OR:   w_ctrl[CTRL_ALUOP_MSB:CTRL_ALUOP_LSB] = ALU_OR;
                    FN_SLT:  w_ctrl[CTRL_ALUOP_MSB:CTRL_ALUOP_LSB] = ALU_SLT;
                    default: w_illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                w_write_reg          = i_rt;
                w_writes             = 1'b1;
                w_ctrl[CTRL_ALUSRC]  = 1'b1;
            end
            OP_LW: begin
                w_write_reg           = i_rt;
                w_writes              = 1'b1;
                w_ctrl[CTRL_ALUSRC]   = 1'b1;
                w_ctrl[CTRL_MEMREAD]  = 1'b1;
                w_ctrl[CTRL_MEMTOREG] = 1'b1;
            end
            OP_SW: begin
                o_reads_rt            = 1'b1;
                w_ctrl[CTRL_ALUSRC]   = 1'b1;
                w_ctrl[CTRL_MEMWRITE] = 1'b1;
            end
            OP_BEQ: begin
                o_reads_rt                              = 1'b1;
                w_ctrl[CTRL_ALUOP_MSB:CTRL_ALUOP_LSB]   = ALU_SUB;
                w_ctrl[CTRL_BRANCH]                     = 1'b1;
            end
            OP_J: begin
                o_reads_rs        = 1'b0;
                w_ctrl[CTRL_JUMP] = 1'b1;
            end
            OP_JAL: begin
                o_reads_rs        = 1'b0;
                w_write_reg       = REG_RA;
                w_writes          = 1'b1;
                w_ctrl[CTRL_JUMP] = 1'b1;
                w_ctrl[CTRL_LINK] = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // An illegal instruction must look exactly like a bubble downstream.
    assign o_illegal   = w_illegal;
    assign o_ctrl      = w_illegal ? '0 : w_ctrl;
    assign o_write_reg = w_illegal ? REG_ZERO : w_write_reg;
    assign o_reg_write = !w_illegal && w_writes && (w_write_reg != REG_ZERO);

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : IF/ID and ID/EX pipeline registers with load-use, stall and
//               flush handling around the combinational decode_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instr,
    input  logic        InstrValid,
    input  logic        ExStall,
    input  logic        Flush,
    output logic [4:0]  ReadRegister1,
    output logic [4:0]  ReadRegister2,
    output logic        FetchStall,
    output logic        DecValid,
    output logic [4:0]  WriteRegister,
    output logic        RegWrite,
    output logic [9:0]  Ctrl,
    output logic [31:0] ImmExt,
    output logic [25:0] JumpIndex,
    output logic        IllegalInstr
);

    logic [31:0]       ifid_instr_q, ifid_instr_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic              dec_valid_q, dec_valid_d;
    logic [4:0]        write_reg_q, write_reg_d;
    logic              reg_write_q, reg_write_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       imm_ext_q, imm_ext_d;
    logic [25:0]       jump_index_q, jump_index_d;
    logic              illegal_q, illegal_d;

    logic [CTRL_W-1:0] w_dec_ctrl;
    logic [4:0]        w_dec_write_reg;
    logic              w_dec_reg_write;
    logic              w_dec_illegal;
    logic              w_reads_rs;
    logic              w_reads_rt;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic              w_load_in_ex;
    logic              w_load_use;

    assign w_rs = ifid_instr_q[25:21];
    assign w_rt = ifid_instr_q[20:16];

    decode_ctrl u_decode_ctrl (
        .i_opcode    (ifid_instr_q[31:26]),
        .i_funct     (ifid_instr_q[5:0]),
        .i_rt        (w_rt),
        .i_rd        (ifid_instr_q[15:11]),
        .o_ctrl      (w_dec_ctrl),
        .o_write_reg (w_dec_write_reg),
        .o_reg_write (w_dec_reg_write),
        .o_illegal   (w_dec_illegal),
        .o_reads_rs  (w_reads_rs),
        .o_reads_rt  (w_reads_rt)
    );

    assign w_load_in_ex = dec_valid_q && ctrl_q[CTRL_MEMREAD] && (write_reg_q != REG_ZERO);
    assign w_load_use   = ifid_valid_q && w_load_in_ex &&
                          ((w_reads_rs && (w_rs == write_reg_q)) ||
                           (w_reads_rt && (w_rt == write_reg_q)));

    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        dec_valid_d  = dec_valid_q;
        write_reg_d  = write_reg_q;
        reg_write_d  = reg_write_q;
        ctrl_d       = ctrl_q;
        imm_ext_d    = imm_ext_q;
        jump_index_d = jump_index_q;
        illegal_d    = 1'b0;

        if (!ExStall || Flush) begin
            // Default for every non-hold case is a bubble into ID/EX.
            dec_valid_d  = 1'b0;
            write_reg_d  = REG_ZERO;
            reg_write_d  = 1'b0;
            ctrl_d       = '0;
            imm_ext_d    = '0;
            jump_index_d = '0;
        end

        if (Flush) begin
            ifid_valid_d = 1'b0;
        end else if (ExStall || w_load_use) begin
            // IF/ID holds; ID/EX either holds (ExStall) or keeps the bubble.
        end else begin
            ifid_instr_d = Instr;
            ifid_valid_d = InstrValid;
            if (ifid_valid_q && w_dec_illegal) begin
                illegal_d = 1'b1;
            end else if (ifid_valid_q) begin
                dec_valid_d  = 1'b1;
                write_reg_d  = w_dec_write_reg;
                reg_write_d  = w_dec_reg_write;
                ctrl_d       = w_dec_ctrl;
                imm_ext_d    = sign_ext16(ifid_instr_q[15:0]);
                jump_index_d = ifid_instr_q[25:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
            dec_valid_q  <= 1'b0;
            write_reg_q  <= '0;
            reg_write_q  <= 1'b0;
            ctrl_q       <= '0;
            imm_ext_q    <= '0;
            jump_index_q <= '0;
            illegal_q    <= 1'b0;
        end else begin
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            dec_valid_q  <= dec_valid_d;
            write_reg_q  <= write_reg_d;
            reg_write_q  <= reg_write_d;
            ctrl_q       <= ctrl_d;
            imm_ext_q    <= imm_ext_d;
            jump_index_q <= jump_index_d;
            illegal_q    <= illegal_d;
        end
    end

    assign ReadRegister1 = rst ? 5'd0 : w_rs;
    assign ReadRegister2 = rst ? 5'd0 : w_rt;
    assign FetchStall    = !rst && !Flush && (ExStall || w_load_use);
    assign DecValid      = dec_valid_q;
    assign WriteRegister = write_reg_q;
    assign RegWrite      = reg_write_q;
    assign Ctrl          = ctrl_q;
    assign ImmExt        = imm_ext_q;
    assign JumpIndex     = jump_index_q;
    assign IllegalInstr  = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Scoreboard bench for decode_stage: reference decode of each
//               accepted instruction is queued and matched at ID/EX output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Instr;
    logic        InstrValid;
    logic        ExStall;
    logic        Flush;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic        FetchStall;
    logic        DecValid;
    logic [4:0]  WriteRegister;
    logic        RegWrite;
    logic [9:0]  Ctrl;
    logic [31:0] ImmExt;
    logic [25:0] JumpIndex;
    logic        IllegalInstr;

    always #5 clk = ~clk;

    decode_stage u_dut (
        .clk           (clk),
        .rst           (rst),
        .Instr         (Instr),
        .InstrValid    (InstrValid),
        .ExStall       (ExStall),
        .Flush         (Flush),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .FetchStall    (FetchStall),
        .DecValid      (DecValid),
        .WriteRegister (WriteRegister),
        .RegWrite      (RegWrite),
        .Ctrl          (Ctrl),
        .ImmExt        (ImmExt),
        .JumpIndex     (JumpIndex),
        .IllegalInstr  (IllegalInstr)
    );

    typedef struct packed {
        logic        legal;
        logic [4:0]  wr;
        logic        rw;
        logic [9:0]  ctrl;
        logic [31:0] imm;
        logic [25:0] jidx;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   mon_en = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    localparam logic [31:0] I_ADD3  = 32'h00221820; // add  $3,$1,$2
    localparam logic [31:0] I_LW5   = 32'h8C050004; // lw   $5,4($0)
    localparam logic [31:0] I_ADD6  = 32'h00A13020; // add  $6,$5,$1
    localparam logic [31:0] I_OR7   = 32'h00223825; // or   $7,$1,$2
    localparam logic [31:0] I_LW0   = 32'h8C200000; // lw   $0,0($1)
    localparam logic [31:0] I_ADD2  = 32'h00001020; // add  $2,$0,$0
    localparam logic [31:0] I_JAL   = 32'h0C000100; // jal  0x0000100
    localparam logic [31:0] I_BAD   = 32'hFC000000; // opcode 0x3F

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Independent reference decode written straight from the ISA table.
    function automatic exp_t model(input logic [31:0] i);
        exp_t e;
        logic [5:0] op;
        logic [5:0] fn;
        op     = i[31:26];
        fn     = i[5:0];
        e      = '0;
        e.legal = 1'b1;
        e.imm  = {{16{i[15]}}, i[15:0]};
        e.jidx = i[25:0];
        case (op)
            6'h00: begin
                e.wr = i[15:11];
                case (fn)
                    6'h20:   e.ctrl = {3'd0, 7'b0000000};
                    6'h22:   e.ctrl = {3'd1, 7'b0000000};
                    6'h24:   e.ctrl = {3'd2, 7'b0000000};
                    6'h25:   e.ctrl = {3'd3, 7'b0000000};
                    6'h2A:   e.ctrl = {3'd4, 7'b0000000};
                    default: e.legal = 1'b0;
                endcase
            end
            6'h08:   begin e.wr = i[20:16]; e.ctrl = {3'd0, 7'b1000000}; end
            6'h23:   begin e.wr = i[20:16]; e.ctrl = {3'd0, 7'b1101000}; end
            6'h2B:   e.ctrl = {3'd0, 7'b1010000};
            6'h04:   e.ctrl = {3'd1, 7'b0000100};
            6'h02:   e.ctrl = {3'd0, 7'b0000010};
            6'h03:   begin e.wr = 5'd31; e.ctrl = {3'd0, 7'b0000011}; end
            default: e.legal = 1'b0;
        endcase
        e.rw = e.legal && (e.wr != 5'd0) &&
               (op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h03);
        if (!e.legal) begin
            e.wr   = 5'd0;
            e.ctrl = '0;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_en && !rst && (DecValid || IllegalInstr)) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {62'd0, DecValid, IllegalInstr}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("valid_illegal", {62'd0, DecValid, IllegalInstr}, {62'd0, mon_e.legal, !mon_e.legal});
                check("write_register", {59'd0, WriteRegister}, {59'd0, mon_e.wr});
                check("reg_write", {63'd0, RegWrite}, {63'd0, mon_e.rw});
                check("ctrl", {54'd0, Ctrl}, {54'd0, mon_e.ctrl});
                if (mon_e.legal) begin
                    check("imm_ext", {32'd0, ImmExt}, {32'd0, mon_e.imm});
                    check("jump_index", {38'd0, JumpIndex}, {38'd0, mon_e.jidx});
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [31:0] ins, output int stalls);
        logic st;
        stalls     = 0;
        st         = 1'b0;
        Instr      = ins;
        InstrValid = 1'b1;
        forever begin
            #1 st = FetchStall;
            @(posedge clk);
            if (!st) break;
            stalls++;
            @(negedge clk);
            if (stalls > 16) begin
                check("fetch_timeout", 64'd1, 64'd0);
                break;
            end
        end
        if (!st) sb.push_back(model(ins));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        InstrValid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] stream [9];
    int st;
    int total;

    initial begin
        stream = '{32'h00222022, 32'h00642824, 32'h00223825, 32'h0022402A, 32'h2029FFFB,
                   32'hAC490008, 32'h10220003, 32'h0AABCDEF, 32'h00221821};
        rst = 1'b1; Instr = '0; InstrValid = 1'b0; ExStall = 1'b1; Flush = 1'b0;
        #12;
        check("rst_fetchstall", {63'd0, FetchStall}, 64'd0);
        check("rst_decvalid", {63'd0, DecValid}, 64'd0);
        check("rst_ctrl", {54'd0, Ctrl}, 64'd0);
        check("rst_illegal", {63'd0, IllegalInstr}, 64'd0);
        check("rst_readregs", {54'd0, ReadRegister1, ReadRegister2}, 64'd0);
        ExStall = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single add: two-edge latency and combinational read ports.
        issue(I_ADD3, st);
        check("add_rs", {59'd0, ReadRegister1}, 64'd1);
        check("add_rt", {59'd0, ReadRegister2}, 64'd2);
        idle(1);
        check("add_latency", {63'd0, DecValid}, 64'd1);
        idle(2);

        // Back-to-back stream of every op plus an illegal funct.
        total = 0;
        foreach (stream[k]) begin
            issue(stream[k], st);
            total += st;
        end
        check("stream_stalls", total, 64'd0);
        idle(3);
        check("stream_drain", sb.size(), 64'd0);

        // Load-use hazard: exactly one stall cycle.
        issue(I_LW5, st);
        issue(I_ADD6, st);
        issue(I_OR7, st);
        check("loaduse_stalls", st, 64'd1);
        idle(3);
        check("loaduse_drain", sb.size(), 64'd0);

        // Load to $0 never creates a hazard.
        total = 0;
        issue(I_LW0, st); total += st;
        issue(I_ADD2, st); total += st;
        issue(I_OR7, st); total += st;
        check("lw_r0_stalls", total, 64'd0);
        idle(3);

        issue(I_JAL, st);
        idle(3);
        check("jal_drain", sb.size(), 64'd0);

        // Flush and ExStall together with a hazard pending.
        issue(I_LW5, st);
        issue(I_ADD6, st);
        #1 check("flush_hz_pending", {63'd0, FetchStall}, 64'd1);
        Flush = 1'b1; ExStall = 1'b1; InstrValid = 1'b0;
        #1 check("flush_fetchstall", {63'd0, FetchStall}, 64'd0);
        @(posedge clk);
        #1;
        sb.delete();
        check("flush_decvalid", {63'd0, DecValid}, 64'd0);
        check("flush_ctrl", {54'd0, Ctrl}, 64'd0);
        @(negedge clk);
        Flush = 1'b0; ExStall = 1'b0;
        idle(3);

        // Illegal opcode, then async reset in the middle of a load-use stall.
        issue(I_BAD, st);
        issue(I_LW5, st);
        issue(I_ADD6, st);
        #1 check("rst_hz_pending", {63'd0, FetchStall}, 64'd1);
        #1 rst = 1'b1;
        #1;
        sb.delete();
        check("async_decvalid", {63'd0, DecValid}, 64'd0);
        check("async_wr_rw", {58'd0, WriteRegister, RegWrite}, 64'd0);
        check("async_ctrl", {54'd0, Ctrl}, 64'd0);
        check("async_imm_jidx", {6'd0, ImmExt, JumpIndex}, 64'd0);
        check("async_fetchstall", {63'd0, FetchStall}, 64'd0);
        check("async_readregs", {54'd0, ReadRegister1, ReadRegister2}, 64'd0);
        InstrValid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(4);
        check("rst_discard", sb.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        check("global_timeout", 64'd1, 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
